// File: rtl/max7219_daisy_tx.sv
// Serial transmitter for a daisy chain of MAX7219 devices.
// Latches one 16-bit frame per device, shifts all bits MSB-first on din with a
// generated serial clock, then strobes load so each device latches its frame.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   i_start           transfer request (accepted only when idle)
//   i_frame           i_frame[16*k +: 16] = {addr, data} for device k
//   o_max7219_clk     serial clock, idles low
//   o_max7219_din     serial data
//   o_max7219_load    latch strobe, idles low
//   o_busy            transfer in progress
//   o_done            one-cycle pulse after a completed transfer
module max7219_daisy_tx #(
  parameter int unsigned G_NB_MATRIX   = 8,
  parameter int unsigned G_CLK_DIV     = 4,
  parameter int unsigned G_LOAD_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic [16*G_NB_MATRIX-1:0]   i_frame,
  output logic                        o_max7219_clk,
  output logic                        o_max7219_din,
  output logic                        o_max7219_load,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int unsigned NB_BITS = 16 * G_NB_MATRIX;
  localparam int unsigned DIV_MAX = (G_CLK_DIV > G_LOAD_CYCLES) ? G_CLK_DIV : G_LOAD_CYCLES;
  localparam int unsigned DIV_W   = $clog2(DIV_MAX) + 1;
  localparam int unsigned BIT_W   = $clog2(NB_BITS) + 1;

  localparam logic [DIV_W-1:0] CLK_LAST  = DIV_W'(G_CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LOAD_LAST = DIV_W'(G_LOAD_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NB_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_LOAD_SETUP,
    S_LOAD_HIGH
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [NB_BITS-1:0] sh_q, sh_d;
  logic               mclk_q, mclk_d;
  logic               din_q, din_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state, counters and shift register; outputs are derived from the
  // next state so the registered outputs line up with the state register.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          sh_d    = i_frame;
          bit_d   = '0;
          div_d   = '0;
          state_d = S_BIT_LOW;
        end
      end
      S_BIT_LOW: begin
        if (div_q == CLK_LAST) begin
          div_d   = '0;
          state_d = S_BIT_HIGH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_BIT_HIGH: begin
        if (div_q == CLK_LAST) begin
          div_d   = '0;
          bit_d   = bit_q + BIT_W'(1);
          sh_d    = {sh_q[NB_BITS-2:0], 1'b0};
          state_d = (bit_q == BIT_LAST) ? S_LOAD_SETUP : S_BIT_LOW;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_LOAD_SETUP: begin
        if (div_q == CLK_LAST) begin
          div_d   = '0;
          state_d = S_LOAD_HIGH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_LOAD_HIGH: begin
        if (div_q == LOAD_LAST) begin
          div_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        div_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    mclk_d = (state_d == S_BIT_HIGH);
    load_d = (state_d == S_LOAD_HIGH);
    busy_d = (state_d != S_IDLE);
    // din only tracks the shift register while bits are on the wire;
    // it moves exactly when BIT_LOW is entered.
    din_d  = ((state_d == S_BIT_LOW) || (state_d == S_BIT_HIGH)) ? sh_d[NB_BITS-1] : 1'b0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      mclk_q  <= 1'b0;
      din_q   <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      mclk_q  <= mclk_d;
      din_q   <= din_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_max7219_clk  = mclk_q;
  assign o_max7219_din  = din_q;
  assign o_max7219_load = load_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_max7219_daisy_tx.sv
// Self-checking bench for max7219_daisy_tx: a 2-device chain (div 2, load 2)
// and a 1-device corner instance (div 1, load 1).
module tb_max7219_daisy_tx;

  localparam int unsigned A_N = 2, A_D = 2, A_L = 2;
  localparam int unsigned B_N = 1, B_D = 1, B_L = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_start = 1'b0;
  logic [31:0] a_frame = '0;
  logic        a_mclk, a_din, a_load, a_busy, a_done;
  logic        b_start = 1'b0;
  logic [15:0] b_frame = '0;
  logic        b_mclk, b_din, b_load, b_busy, b_done;

  max7219_daisy_tx #(.G_NB_MATRIX(A_N), .G_CLK_DIV(A_D), .G_LOAD_CYCLES(A_L)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_frame(a_frame),
    .o_max7219_clk(a_mclk), .o_max7219_din(a_din), .o_max7219_load(a_load),
    .o_busy(a_busy), .o_done(a_done)
  );

  max7219_daisy_tx #(.G_NB_MATRIX(B_N), .G_CLK_DIV(B_D), .G_LOAD_CYCLES(B_L)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_frame(b_frame),
    .o_max7219_clk(b_mclk), .o_max7219_din(b_din), .o_max7219_load(b_load),
    .o_busy(b_busy), .o_done(b_done)
  );

  // Observation mux so one capture routine serves both instances.
  logic sel = 1'b0;
  wire o_mclk = sel ? b_mclk : a_mclk;
  wire o_din  = sel ? b_din  : a_din;
  wire o_load = sel ? b_load : a_load;
  wire o_busy = sel ? b_busy : a_busy;
  wire o_done = sel ? b_done : a_done;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference timing: every bit costs a low and a high half period, then one
  // setup half period and the load strobe.
  function automatic int exp_busy(input int n, input int d, input int l);
    return 16 * n * 2 * d + d + l;
  endfunction

  // Bits a device chain should see, in wire order, packed into a word.
  function automatic logic [31:0] exp_stream(input logic [31:0] frame, input int nb);
    logic [31:0] w = '0;
    for (int i = nb - 1; i >= 0; i--) w = {w[30:0], frame[i]};
    return w;
  endfunction

  // One transfer: start, capture din at each serial clock rise, count busy,
  // load and done cycles. poke >= 0 pulses i_start with all-ones after that
  // many serial clock edges.
  task automatic do_xfer(input bit s, input logic [31:0] frame, input int n,
                         input int d, input int l, input int poke, input string tag);
    int nb = 16 * n;
    int eb = exp_busy(n, d, l);
    logic [31:0] got = '0;
    int edges = 0, busy_cnt = 0, load_cnt = 0, overlap = 0, unstable = 0;
    int done_cnt = 0, done_at = -1;
    logic prev_clk = 1'b0, cur_bit = 1'b0;
    bit poked = 1'b0, poke_clr = 1'b0;
    sel = s;
    @(negedge clk);
    if (s) begin b_frame = frame[15:0]; b_start = 1'b1; end
    else   begin a_frame = frame;       a_start = 1'b1; end
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
    for (int c = 0; c < eb + 20; c++) begin
      if (o_done) begin done_cnt++; done_at = c; end
      if (o_busy) busy_cnt++;
      if (o_load) load_cnt++;
      if (o_mclk && o_load) overlap++;
      if (o_mclk && !prev_clk) begin
        edges++;
        cur_bit = o_din;
        got = {got[30:0], o_din};
      end else if (o_mclk && (o_din !== cur_bit)) begin
        unstable++;
      end
      prev_clk = o_mclk;
      if (poke_clr) begin
        a_start = 1'b0;
        a_frame = frame;
        poke_clr = 1'b0;
      end
      if (poke >= 0 && edges == poke && !poked) begin
        poked = 1'b1;
        poke_clr = 1'b1;
        a_start = 1'b1;
        a_frame = 32'hFFFF_FFFF;
      end
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(eb));
    chk({tag, "_clk_edges"}, 64'(edges), 64'(nb));
    chk({tag, "_din_stream"}, 64'(got), 64'(exp_stream(frame, nb)));
    chk({tag, "_load_cycles"}, 64'(load_cnt), 64'(l));
    chk({tag, "_clk_load_overlap"}, 64'(overlap), 64'd0);
    chk({tag, "_din_unstable"}, 64'(unstable), 64'd0);
    chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, "_done_cycle"}, 64'(done_at), 64'(eb));
  endtask

  initial begin
    logic [31:0] fr;
    int edges;
    logic prev_clk;
    int d1, d2, gap_busy, dcnt;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_a_outputs", 64'({a_mclk, a_din, a_load, a_busy, a_done}), 64'd0);
    chk("rst_b_outputs", 64'({b_mclk, b_din, b_load, b_busy, b_done}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic transfer
    do_xfer(1'b0, 32'h0C01_0F00, A_N, A_D, A_L, -1, "basic");

    // Start while busy is ignored
    fr = $urandom;
    do_xfer(1'b0, fr, A_N, A_D, A_L, 5, "start_busy");

    // Random frames
    for (int i = 0; i < 3; i++) begin
      fr = $urandom;
      do_xfer(1'b0, fr, A_N, A_D, A_L, -1, "rand_a");
    end

    // Back-to-back: i_start held high through o_done
    sel = 1'b0;
    d1 = -1; d2 = -1; gap_busy = 0;
    @(negedge clk);
    a_frame = $urandom;
    a_start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 400 && d2 < 0; c++) begin
      if (c == d1 + 1 && d1 >= 0) gap_busy = a_busy;
      if (a_done) begin
        if (d1 < 0) d1 = c;
        else begin d2 = c; a_start = 1'b0; end
      end
      @(negedge clk);
    end
    a_start = 1'b0;
    chk("b2b_first_done", 64'(d1), 64'(exp_busy(A_N, A_D, A_L)));
    chk("b2b_no_gap", 64'(gap_busy), 64'd1);
    chk("b2b_done_spacing", 64'(d2 - d1), 64'(exp_busy(A_N, A_D, A_L) + 1));
    repeat (3) @(negedge clk);
    chk("b2b_idle_after", 64'(a_busy), 64'd0);

    // Reset mid-transfer
    @(negedge clk);
    a_frame = $urandom;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    edges = 0;
    prev_clk = 1'b0;
    for (int c = 0; c < 400 && edges < 10; c++) begin
      if (a_mclk && !prev_clk) edges++;
      prev_clk = a_mclk;
      if (edges < 10) @(negedge clk);
    end
    chk("rstmid_reached_bit10", 64'(edges), 64'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_outputs", 64'({a_mclk, a_din, a_load, a_busy, a_done}), 64'd0);
    dcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_done) dcnt++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (a_done || a_busy) dcnt++;
    end
    chk("rstmid_no_done", 64'(dcnt), 64'd0);
    fr = $urandom;
    do_xfer(1'b0, fr, A_N, A_D, A_L, -1, "after_rst");

    // Corner: one device, divide 1, load 1
    do_xfer(1'b1, 32'h0000_0A0F, B_N, B_D, B_L, -1, "corner");
    for (int i = 0; i < 2; i++) begin
      fr = {16'h0, 16'($urandom)};
      do_xfer(1'b1, fr, B_N, B_D, B_L, -1, "rand_b");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
